stride_prefetch_issuer: RTL and testbench
=========================================

// Module: stride_prefetch_issuer
// PURPOSE
// - Consumes the observed value stream and the stride detector's predictions.
// - On a confident prediction, issues a burst of PF_DEPTH predicted addresses over a valid/ready port.
// - Sits between the stride detector and the prefetch/request queue; sequences prediction into traffic.
// PARAMETERS
// - MAX_STRIDE_WIDTH  5  stride width from detector; strides are signed two's complement.
// - PF_DEPTH          4  addresses issued per trigger, 1..15.
// - CNT_WIDTH         8  width of the saturating drop counter.
// PORTS
// - clk_i             in   1         clock; all state updates on posedge.
// - rst_i             in   1         reset, asynchronous, active-high.
// - cfg_enable_i      in   1         1 = new triggers accepted.
// - value_i           in   32        observed value, same stream as the detector.
// - valid_i           in   1         value_i valid this cycle.
// - stride_1_i        in   MSW       detector stride 1.
// - stride_1_valid_i  in   1         stride 1 confident.
// - stride_2_i        in   MSW       detector stride 2.
// - stride_2_valid_i  in   1         double-stride pattern confident.
// - pf_addr_o         out  32        predicted address.
// - pf_valid_o        out  1         pf_addr_o valid.
// - pf_ready_i        in   1         consumer accepts when pf_valid_o & pf_ready_i.
// - busy_o            out  1         FSM not IDLE.
// - drop_cnt_o        out  CNT_WIDTH overwritten pending triggers, saturating.
// BEHAVIOUR
// - Reset: pf_valid_o=0, pf_addr_o=0, busy_o=0, drop_cnt_o=0, phase=0, pending empty, state IDLE.
// - Phase bit: toggles on every valid_i, independent of state, and mirrors the detector's slot alternation.
//   - valid_i at phase p carries the stride for slot p.
//   - Slot 0 is stride_1_i; slot 1 is stride_2_i.
// - Trigger: valid_i & cfg_enable_i & stride_1_valid_i, with detector outputs sampled in the same cycle.
//   - Latches base=value_i.
//   - Mode is DOUBLE if stride_2_valid_i, else SINGLE.
//   - First slot used is ~p.
// - Arithmetic: stride sign-extended to 32 bits; addr = prev + stride, mod 2^32 (wraps silently).
//   - SINGLE: addr_k = base + k*s1, k = 1..PF_DEPTH.
//   - DOUBLE: strides alternate, starting with slot ~p.
// - FSM: IDLE and ISSUE.
//   - IDLE -> ISSUE on trigger; pf_valid_o=1 the next cycle, with pf_addr_o = base + first stride (1-cycle latency).
//   - ISSUE, on accept: count+1 and next address presented the next cycle.
//   - ISSUE -> IDLE after the PF_DEPTH-th accept; pf_valid_o=0 the next cycle unless pending is loaded.
// - Handshake: pf_addr_o and pf_valid_o stay stable while pf_valid_o & ~pf_ready_i; a beat is never withdrawn.
// - Trigger during ISSUE: stored in a 1-entry pending register (base, mode, slot).
//   - A second trigger overwrites the entry and increments drop_cnt_o, saturating.
//   - Pending is loaded on the next accept, or at burst end, whichever comes first.
//   - Loading resets count and presents pending base + its first stride.
// - Abort: stride_1_valid_i low during ISSUE (pending empty) means the current beat completes, then IDLE.
//   - cfg_enable_i low behaves the same and also clears pending.
// - Simultaneous accept and new trigger in the same cycle: the new trigger wins and is loaded directly.
//   - It does not count as a drop.
// - Reset asserted mid-burst: immediate return to reset values; an in-flight beat is lost.
// STRUCTURE
// - stride_pkg holds:
//   - typedef pf_mode_e {PF_SINGLE, PF_DOUBLE};
//   - typedef pf_state_e {PF_IDLE, PF_ISSUE};
//   - function sext_stride(); shared with the detector.
// - Sub-module stride_addr_gen (combinational): takes prev addr, mode, slot, and both strides; returns next addr and next slot.
// - FSM, pending register, phase bit and counters live in the top module.
// TESTING
// - SINGLE, s1=4, value 0x100, ready=1 -> 0x104,0x108,0x10C,0x110 on 4 consecutive cycles; busy_o drops after.
// - SINGLE, s1=5'b11100 (-4), value 0x2 -> 0xFFFFFFFE,0xFFFFFFFA,0xFFFFFFF6,0xFFFFFFF2 (wrap).
// - DOUBLE, s1=1, s2=3, trigger at phase 0, value 0x40 -> 0x43,0x44,0x47,0x48.
// - Backpressure: ready low 5 cycles on the first beat -> addr 0x104 held stable; the burst then resumes unchanged.
// - Two triggers (0x200, then 0x300) during a stalled burst -> drop_cnt_o=1; after the accept, next addr is 0x304.
// - rst_i pulsed mid-burst and stride_1_valid_i dropped mid-burst -> reset values next edge / one more beat then IDLE.

Source files
------------

// File: rtl/stride_pkg.sv
// Types and helpers shared by the stride detector and the prefetch issuer.
package stride_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic {PF_SINGLE, PF_DOUBLE} pf_mode_e;
    typedef enum logic {PF_IDLE, PF_ISSUE} pf_state_e;

    // Sign-extends the low `width` bits of raw to a full address-width offset.
    function automatic logic [ADDR_W-1:0] sext_stride(input logic [ADDR_W-1:0] raw,
                                                      input int unsigned width);
        logic signed [ADDR_W-1:0] shifted;
        shifted = signed'(raw << (ADDR_W - width));
        return shifted >>> (ADDR_W - width);
    endfunction

endpackage

// File: rtl/stride_addr_gen.sv
// Next-address step for a prefetch burst: adds the stride selected by mode/slot
// to the previous address and advances the slot for double-stride patterns.
module stride_addr_gen
    import stride_pkg::*;
#(
    parameter int MAX_STRIDE_WIDTH = 5
) (
    input  logic [ADDR_W-1:0]           prev_addr_i,
    input  pf_mode_e                    mode_i,
    input  logic                        slot_i,
    input  logic [MAX_STRIDE_WIDTH-1:0] stride_1_i,
    input  logic [MAX_STRIDE_WIDTH-1:0] stride_2_i,
    output logic [ADDR_W-1:0]           next_addr_o,
    output logic                        next_slot_o
);

    logic [MAX_STRIDE_WIDTH-1:0] rawStride;
    logic [ADDR_W-1:0]           offset;

    // Slot 1 selects stride 2 only in double mode; single mode always steps by stride 1.
    always_comb begin
        rawStride   = (mode_i == PF_DOUBLE && slot_i) ? stride_2_i : stride_1_i;
        offset      = sext_stride(ADDR_W'(rawStride), MAX_STRIDE_WIDTH);
        next_addr_o = prev_addr_i + offset;
        next_slot_o = ~slot_i;
    end

endmodule

// File: rtl/stride_prefetch_issuer.sv
// Turns confident stride predictions into bursts of PF_DEPTH prefetch addresses
// on a valid/ready port, with a one-entry pending slot for triggers during a burst.
module stride_prefetch_issuer
    import stride_pkg::*;
#(
    parameter int MAX_STRIDE_WIDTH = 5,
    parameter int PF_DEPTH         = 4,
    parameter int CNT_WIDTH        = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cfg_enable_i,
    input  logic [ADDR_W-1:0]           value_i,
    input  logic                        valid_i,
    input  logic [MAX_STRIDE_WIDTH-1:0] stride_1_i,
    input  logic                        stride_1_valid_i,
    input  logic [MAX_STRIDE_WIDTH-1:0] stride_2_i,
    input  logic                        stride_2_valid_i,
    output logic [ADDR_W-1:0]           pf_addr_o,
    output logic                        pf_valid_o,
    input  logic                        pf_ready_i,
    output logic                        busy_o,
    output logic [CNT_WIDTH-1:0]        drop_cnt_o
);

    localparam int                BEAT_W    = 4;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PF_DEPTH - 1);

    pf_state_e                   state_q, state_d;
    logic                        phase_q, phase_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic                        valid_q, valid_d;
    logic [BEAT_W-1:0]           count_q, count_d;
    logic                        slot_q, slot_d;
    pf_mode_e                    mode_q, mode_d;
    logic [MAX_STRIDE_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic                        abort_q, abort_d;
    logic                        pendValid_q, pendValid_d;
    logic [ADDR_W-1:0]           pendBase_q, pendBase_d;
    pf_mode_e                    pendMode_q, pendMode_d;
    logic                        pendSlot_q, pendSlot_d;
    logic [MAX_STRIDE_WIDTH-1:0] pendS1_q, pendS1_d, pendS2_q, pendS2_d;
    logic [CNT_WIDTH-1:0]        dropCnt_q, dropCnt_d;

    logic                        trigger, accept, abortNow, loadTrig, loadPend;
    pf_mode_e                    trigMode;
    logic [ADDR_W-1:0]           genPrev, genAddr;
    pf_mode_e                    genMode;
    logic                        genSlot, genSlotNext;
    logic [MAX_STRIDE_WIDTH-1:0] genS1, genS2;

    assign trigger  = valid_i & cfg_enable_i & stride_1_valid_i;
    assign trigMode = stride_2_valid_i ? PF_DOUBLE : PF_SINGLE;
    assign accept   = valid_q & pf_ready_i;
    assign abortNow = (state_q == PF_ISSUE) &
                      ((~stride_1_valid_i & ~pendValid_q) | ~cfg_enable_i);
    assign loadTrig = trigger & ((state_q == PF_IDLE) | accept);
    assign loadPend = (state_q == PF_ISSUE) & accept & ~trigger & pendValid_q & cfg_enable_i;

    // The single address step is shared: it starts a new burst or advances the current one.
    always_comb begin
        genPrev = addr_q;
        genMode = mode_q;
        genSlot = slot_q;
        genS1   = s1_q;
        genS2   = s2_q;
        if (loadTrig) begin
            genPrev = value_i;
            genMode = trigMode;
            genSlot = ~phase_q;
            genS1   = stride_1_i;
            genS2   = stride_2_i;
        end else if (loadPend) begin
            genPrev = pendBase_q;
            genMode = pendMode_q;
            genSlot = pendSlot_q;
            genS1   = pendS1_q;
            genS2   = pendS2_q;
        end
    end

    stride_addr_gen #(
        .MAX_STRIDE_WIDTH(MAX_STRIDE_WIDTH)
    ) u_addr_gen (
        .prev_addr_i(genPrev),
        .mode_i     (genMode),
        .slot_i     (genSlot),
        .stride_1_i (genS1),
        .stride_2_i (genS2),
        .next_addr_o(genAddr),
        .next_slot_o(genSlotNext)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = valid_i ? ~phase_q : phase_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        count_d     = count_q;
        slot_d      = slot_q;
        mode_d      = mode_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        abort_d     = abort_q;
        pendValid_d = pendValid_q;
        pendBase_d  = pendBase_q;
        pendMode_d  = pendMode_q;
        pendSlot_d  = pendSlot_q;
        pendS1_d    = pendS1_q;
        pendS2_d    = pendS2_q;
        dropCnt_d   = dropCnt_q;

        if (state_q == PF_ISSUE) begin
            if (!cfg_enable_i) pendValid_d = 1'b0;
            if (abortNow) abort_d = 1'b1;
            if (accept && !loadTrig && !loadPend) begin
                if (abort_d || count_q == LAST_BEAT) begin
                    state_d = PF_IDLE;
                    valid_d = 1'b0;
                    abort_d = 1'b0;
                end else begin
                    addr_d  = genAddr;
                    slot_d  = genSlotNext;
                    count_d = count_q + 1'b1;
                end
            end else if (!accept && trigger) begin
                // A trigger that cannot be served yet parks here; replacing one counts as a drop.
                pendValid_d = 1'b1;
                pendBase_d  = value_i;
                pendMode_d  = trigMode;
                pendSlot_d  = ~phase_q;
                pendS1_d    = stride_1_i;
                pendS2_d    = stride_2_i;
                if (pendValid_q && dropCnt_q != {CNT_WIDTH{1'b1}})
                    dropCnt_d = dropCnt_q + 1'b1;
            end
        end

        if (loadTrig || loadPend) begin
            state_d     = PF_ISSUE;
            valid_d     = 1'b1;
            addr_d      = genAddr;
            slot_d      = genSlotNext;
            mode_d      = genMode;
            s1_d        = genS1;
            s2_d        = genS2;
            count_d     = '0;
            abort_d     = 1'b0;
            pendValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= PF_IDLE;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            count_q     <= '0;
            slot_q      <= 1'b0;
            mode_q      <= PF_SINGLE;
            s1_q        <= '0;
            s2_q        <= '0;
            abort_q     <= 1'b0;
            pendValid_q <= 1'b0;
            pendBase_q  <= '0;
            pendMode_q  <= PF_SINGLE;
            pendSlot_q  <= 1'b0;
            pendS1_q    <= '0;
            pendS2_q    <= '0;
            dropCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            slot_q      <= slot_d;
            mode_q      <= mode_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            abort_q     <= abort_d;
            pendValid_q <= pendValid_d;
            pendBase_q  <= pendBase_d;
            pendMode_q  <= pendMode_d;
            pendSlot_q  <= pendSlot_d;
            pendS1_q    <= pendS1_d;
            pendS2_q    <= pendS2_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

    assign pf_addr_o  = addr_q;
    assign pf_valid_o = valid_q;
    assign busy_o     = (state_q == PF_ISSUE);
    assign drop_cnt_o = dropCnt_q;

endmodule

// File: tb/tb_stride_prefetch_issuer.sv
// Bench for stride_prefetch_issuer: directed vector table, hand-written corner
// sequences, and a randomized run against a burst-level reference model.
module tb_stride_prefetch_issuer;

    localparam int DEPTH = 4;

    typedef struct {
        bit          rst;
        bit          valid;
        logic [31:0] value;
        logic [4:0]  s1;
        bit          s1v;
        logic [4:0]  s2;
        bit          s2v;
        bit          en;
        bit          ready;
        bit          eValid;
        logic [31:0] eAddr;
        bit          eBusy;
        logic [7:0]  eDrop;
    } vec_t;

    typedef struct {
        logic [31:0] base;
        bit          dbl;
        bit          slot;
        logic [31:0] s1;
        logic [31:0] s2;
    } trig_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_enable_i;
    logic [31:0] value_i;
    logic        valid_i;
    logic [4:0]  stride_1_i;
    logic        stride_1_valid_i;
    logic [4:0]  stride_2_i;
    logic        stride_2_valid_i;
    logic [31:0] pf_addr_o;
    logic        pf_valid_o;
    logic        pf_ready_i;
    logic        busy_o;
    logic [7:0]  drop_cnt_o;

    int passCount = 0;
    int checkCount = 0;

    bit          mBusy, mAbort, mPend, mPhase;
    int          mBeat, mDrops;
    trig_t       mPendT;
    logic [31:0] mBurst [DEPTH];

    vec_t tbl[$];

    stride_prefetch_issuer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_enable_i    (cfg_enable_i),
        .value_i         (value_i),
        .valid_i         (valid_i),
        .stride_1_i      (stride_1_i),
        .stride_1_valid_i(stride_1_valid_i),
        .stride_2_i      (stride_2_i),
        .stride_2_valid_i(stride_2_valid_i),
        .pf_addr_o       (pf_addr_o),
        .pf_valid_o      (pf_valid_o),
        .pf_ready_i      (pf_ready_i),
        .busy_o          (busy_o),
        .drop_cnt_o      (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mkVec(bit rst, bit valid, logic [31:0] value, logic [4:0] s1, bit s1v,
                                   logic [4:0] s2, bit s2v, bit en, bit ready,
                                   bit eValid, logic [31:0] eAddr, bit eBusy, logic [7:0] eDrop);
        vec_t v;
        v.rst = rst; v.valid = valid; v.value = value; v.s1 = s1; v.s1v = s1v;
        v.s2 = s2; v.s2v = s2v; v.en = en; v.ready = ready;
        v.eValid = eValid; v.eAddr = eAddr; v.eBusy = eBusy; v.eDrop = eDrop;
        return v;
    endfunction

    function automatic logic [31:0] sx(logic [4:0] s);
        return {{27{s[4]}}, s};
    endfunction

    // k-th address of a burst (k = 1..DEPTH) in closed form.
    function automatic logic [31:0] beatAddr(trig_t t, int k);
        logic [31:0] kk, firstS, secondS;
        kk = 32'(k);
        if (!t.dbl) return t.base + kk * t.s1;
        firstS  = t.slot ? t.s2 : t.s1;
        secondS = t.slot ? t.s1 : t.s2;
        return t.base + ((kk + 32'd1) / 32'd2) * firstS + (kk / 32'd2) * secondS;
    endfunction

    task automatic modelReset();
        mBusy = 0; mAbort = 0; mPend = 0; mPhase = 0; mBeat = 0; mDrops = 0;
    endtask

    task automatic startBurst(input trig_t t);
        mBusy = 1; mBeat = 0; mAbort = 0; mPend = 0;
        for (int k = 1; k <= DEPTH; k++) mBurst[k-1] = beatAddr(t, k);
    endtask

    task automatic modelStep(input vec_t v);
        trig_t nt;
        bit    trig, abortNow;
        if (v.rst) begin
            modelReset();
            return;
        end
        trig    = v.valid && v.en && v.s1v;
        nt.base = v.value;
        nt.dbl  = v.s2v;
        nt.slot = !mPhase;
        nt.s1   = sx(v.s1);
        nt.s2   = sx(v.s2);
        if (mBusy) begin
            abortNow = (!v.s1v && !mPend) || !v.en;
            if (!v.en) mPend = 0;
            if (v.ready) begin
                if (trig) startBurst(nt);
                else if (mPend) startBurst(mPendT);
                else if (mAbort || abortNow || mBeat == DEPTH - 1) begin
                    mBusy = 0;
                    mAbort = 0;
                end else begin
                    mBeat++;
                    mAbort = mAbort || abortNow;
                end
            end else begin
                mAbort = mAbort || abortNow;
                if (trig) begin
                    if (mPend && mDrops < 255) mDrops++;
                    mPendT = nt;
                    mPend = 1;
                end
            end
        end else if (trig) begin
            startBurst(nt);
        end
        if (v.valid) mPhase = !mPhase;
    endtask

    task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic checkOutput(input string tag, input bit eValid, input logic [31:0] eAddr,
                               input bit chkAddr, input bit eBusy, input logic [7:0] eDrop);
        checkField({tag, ".valid"}, 32'(pf_valid_o), 32'(eValid));
        checkField({tag, ".busy"}, 32'(busy_o), 32'(eBusy));
        checkField({tag, ".drop"}, 32'(drop_cnt_o), 32'(eDrop));
        if (chkAddr) checkField({tag, ".addr"}, pf_addr_o, eAddr);
    endtask

    // Drives one cycle of inputs at the falling edge and returns at the next falling edge.
    task automatic applyStimulus(input vec_t v);
        rst_i            = v.rst;
        valid_i          = v.valid;
        value_i          = v.value;
        stride_1_i       = v.s1;
        stride_1_valid_i = v.s1v;
        stride_2_i       = v.s2;
        stride_2_valid_i = v.s2v;
        cfg_enable_i     = v.en;
        pf_ready_i       = v.ready;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic runVec(input string tag, input vec_t v);
        applyStimulus(v);
        checkOutput(tag, v.eValid, v.eAddr, v.eValid || v.rst, v.eBusy, v.eDrop);
    endtask

    initial begin
        vec_t v;
        rst_i = 1; valid_i = 0; value_i = 0; stride_1_i = 0; stride_1_valid_i = 0;
        stride_2_i = 0; stride_2_valid_i = 0; cfg_enable_i = 0; pf_ready_i = 0;

        // Single stride +4 from 0x100.
        tbl.push_back(mkVec(1, 0, 0,        5'd4, 0, 0, 0, 1, 0, 0, 32'h0,   0, 0));
        tbl.push_back(mkVec(0, 1, 32'h100,  5'd4, 1, 0, 0, 1, 1, 1, 32'h104, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'd4, 1, 0, 0, 1, 1, 1, 32'h108, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'd4, 1, 0, 0, 1, 1, 1, 32'h10C, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'd4, 1, 0, 0, 1, 1, 1, 32'h110, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'd4, 1, 0, 0, 1, 1, 0, 32'h0,   0, 0));
        // Negative stride wrapping below zero.
        tbl.push_back(mkVec(1, 0, 0,        5'h1C, 0, 0, 0, 1, 0, 0, 32'h0,        0, 0));
        tbl.push_back(mkVec(0, 1, 32'h2,    5'h1C, 1, 0, 0, 1, 1, 1, 32'hFFFFFFFE, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'h1C, 1, 0, 0, 1, 1, 1, 32'hFFFFFFFA, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'h1C, 1, 0, 0, 1, 1, 1, 32'hFFFFFFF6, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'h1C, 1, 0, 0, 1, 1, 1, 32'hFFFFFFF2, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'h1C, 1, 0, 0, 1, 1, 0, 32'h0,        0, 0));
        // Double stride, trigger at phase 0 so slot 1 (stride 2) leads.
        tbl.push_back(mkVec(1, 0, 0,        5'd1, 0, 5'd3, 0, 1, 0, 0, 32'h0,  0, 0));
        tbl.push_back(mkVec(0, 1, 32'h40,   5'd1, 1, 5'd3, 1, 1, 1, 1, 32'h43, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'd1, 1, 5'd3, 1, 1, 1, 1, 32'h44, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'd1, 1, 5'd3, 1, 1, 1, 1, 32'h47, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'd1, 1, 5'd3, 1, 1, 1, 1, 32'h48, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,        5'd1, 1, 5'd3, 1, 1, 1, 0, 32'h0,  0, 0));

        @(negedge clk_i);
        for (int i = 0; i < tbl.size(); i++) runVec($sformatf("tbl%0d", i), tbl[i]);

        // Backpressure on the first beat holds the address, then the burst resumes.
        runVec("bp.rst", mkVec(1, 0, 0, 5'd4, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0));
        runVec("bp.trig", mkVec(0, 1, 32'h100, 5'd4, 1, 0, 0, 1, 0, 1, 32'h104, 1, 0));
        for (int i = 0; i < 5; i++)
            runVec($sformatf("bp.hold%0d", i), mkVec(0, 0, 0, 5'd4, 1, 0, 0, 1, 0, 1, 32'h104, 1, 0));
        runVec("bp.b2", mkVec(0, 0, 0, 5'd4, 1, 0, 0, 1, 1, 1, 32'h108, 1, 0));
        runVec("bp.b3", mkVec(0, 0, 0, 5'd4, 1, 0, 0, 1, 1, 1, 32'h10C, 1, 0));
        runVec("bp.b4", mkVec(0, 0, 0, 5'd4, 1, 0, 0, 1, 1, 1, 32'h110, 1, 0));
        runVec("bp.end", mkVec(0, 0, 0, 5'd4, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0));

        // Two triggers while stalled: the second overwrites pending and counts a drop.
        runVec("pend.rst", mkVec(1, 0, 0, 5'd4, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0));
        runVec("pend.trig", mkVec(0, 1, 32'h100, 5'd4, 1, 0, 0, 1, 0, 1, 32'h104, 1, 0));
        runVec("pend.t200", mkVec(0, 1, 32'h200, 5'd4, 1, 0, 0, 1, 0, 1, 32'h104, 1, 0));
        runVec("pend.t300", mkVec(0, 1, 32'h300, 5'd4, 1, 0, 0, 1, 0, 1, 32'h104, 1, 1));
        runVec("pend.load", mkVec(0, 0, 0, 5'd4, 1, 0, 0, 1, 1, 1, 32'h304, 1, 1));
        runVec("pend.next", mkVec(0, 0, 0, 5'd4, 1, 0, 0, 1, 1, 1, 32'h308, 1, 1));

        // Asynchronous reset in the middle of a burst.
        runVec("ar.rst", mkVec(1, 0, 0, 5'd4, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0));
        runVec("ar.trig", mkVec(0, 1, 32'h100, 5'd4, 1, 0, 0, 1, 1, 1, 32'h104, 1, 0));
        runVec("ar.b2", mkVec(0, 0, 0, 5'd4, 1, 0, 0, 1, 1, 1, 32'h108, 1, 0));
        #2 rst_i = 1;
        #1 checkOutput("ar.async", 0, 32'h0, 1, 0, 0);
        runVec("ar.hold", mkVec(1, 0, 0, 5'd4, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0));

        // Detector confidence lost: the presented beat completes, then idle.
        runVec("ab.trig", mkVec(0, 1, 32'h100, 5'd4, 1, 0, 0, 1, 1, 1, 32'h104, 1, 0));
        runVec("ab.b2", mkVec(0, 0, 0, 5'd4, 1, 0, 0, 1, 1, 1, 32'h108, 1, 0));
        runVec("ab.drop", mkVec(0, 0, 0, 5'd4, 0, 0, 0, 1, 0, 1, 32'h108, 1, 0));
        runVec("ab.end", mkVec(0, 0, 0, 5'd4, 0, 0, 0, 1, 1, 0, 32'h0, 0, 0));

        // Randomized traffic against the burst-level model.
        v = mkVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(v);
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            v.rst   = ($urandom_range(0, 399) == 0);
            v.valid = 1'($urandom_range(0, 1));
            v.value = $urandom;
            v.s1    = 5'($urandom);
            v.s1v   = ($urandom_range(0, 9) != 0);
            v.s2    = 5'($urandom);
            v.s2v   = 1'($urandom_range(0, 1));
            v.en    = ($urandom_range(0, 19) != 0);
            v.ready = ($urandom_range(0, 9) < 6);
            applyStimulus(v);
            modelStep(v);
            checkOutput($sformatf("rand%0d", c), mBusy, mBurst[mBeat], mBusy, mBusy, 8'(mDrops));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
